// File: rtl/audio_pkg.sv
// Shared audio-path types and widths used by the gain estimator
// and its serial divider.
package audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam int SHIFT_W  = 5;
    localparam int DIV_W    = 31;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        ACCUM,
        DIVIDE
    } gain_state_e;

    function automatic sample_t max_s(input sample_t a, input sample_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// The dividend register shifts left and fills with quotient bits.
module serial_divider
    import audio_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  sample_t          divisor,
    output logic [DIV_W-1:0] quotient,
    output logic             done,
    output logic             div_by_zero
);

    localparam logic [4:0] STEPS = 5'(DIV_W);

    logic [DIV_W-1:0] acc_q, acc_d;
    sample_t          rem_q, rem_d;
    sample_t          dsr_q, dsr_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [SAMPLE_W:0] trial;
    logic [SAMPLE_W:0] diff;
    logic              ge;

    always_comb begin
        trial  = {rem_q, acc_q[DIV_W-1]};
        diff   = trial - {1'b0, dsr_q};
        ge     = trial >= {1'b0, dsr_q};
        acc_d  = acc_q;
        rem_d  = rem_q;
        dsr_d  = dsr_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        dbz_d  = dbz_q;
        done_d = 1'b0;
        if (start) begin
            acc_d = dividend;
            rem_d = '0;
            dsr_d = divisor;
            cnt_d = STEPS;
            run_d = 1'b1;
            dbz_d = (divisor == '0);
        end else if (run_q) begin
            acc_d = {acc_q[DIV_W-2:0], ge};
            rem_d = ge ? diff[SAMPLE_W-1:0] : trial[SAMPLE_W-1:0];
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
            dbz_q  <= dbz_d;
        end
    end

    assign quotient    = acc_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: rtl/gain_estimator.sv
// Windowed peak detector that derives the scalar/shift gain pair
// mapping the observed peak onto TARGET.
module gain_estimator
    import audio_pkg::*;
#(
    parameter int                 WINDOW = 1024,
    parameter logic [15:0]        TARGET = 16'hC000,
    parameter logic [SHIFT_W-1:0] SHIFT  = 5'd8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic [SAMPLE_W-1:0] scalar,
    output logic [SHIFT_W-1:0]  shift,
    output logic                gain_valid,
    output logic                busy
);

    localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(TARGET) << SHIFT;
    localparam sample_t          LAST     = 16'(WINDOW - 1);
    localparam sample_t          UNITY    = 16'd1 << SHIFT;

    gain_state_e state_q, state_d;
    sample_t     peak_q, peak_d;
    sample_t     count_q, count_d;
    sample_t     scalar_q, scalar_d;
    logic        gain_valid_q, gain_valid_d;
    logic        busy_q, busy_d;

    sample_t          hi;
    logic             close;
    logic [DIV_W-1:0] quo;
    logic             div_done;
    logic             div_zero;

    serial_divider u_div (
        .clk         (clk),
        .reset       (reset),
        .start       (close),
        .dividend    (DIVIDEND),
        .divisor     (hi),
        .quotient    (quo),
        .done        (div_done),
        .div_by_zero (div_zero)
    );

    always_comb begin
        hi           = max_s(peak_q, sample_in);
        close        = sample_valid && (count_q == LAST);
        state_d      = state_q;
        peak_d       = peak_q;
        count_d      = count_q;
        scalar_d     = scalar_q;
        busy_d       = busy_q;
        gain_valid_d = 1'b0;
        if (sample_valid) begin
            peak_d  = close ? '0 : hi;
            count_d = close ? '0 : count_q + 16'd1;
        end
        unique case (state_q)
            ACCUM: begin
                if (close) begin
                    state_d = DIVIDE;
                    busy_d  = 1'b1;
                end
            end
            DIVIDE: begin
                if (div_done) begin
                    state_d      = ACCUM;
                    busy_d       = 1'b0;
                    gain_valid_d = 1'b1;
                    // Zero divisor and oversized quotients both saturate
                    scalar_d = (div_zero || |quo[DIV_W-1:SAMPLE_W])
                             ? 16'hFFFF : quo[SAMPLE_W-1:0];
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ACCUM;
            peak_q       <= '0;
            count_q      <= '0;
            scalar_q     <= UNITY;
            gain_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            peak_q       <= peak_d;
            count_q      <= count_d;
            scalar_q     <= scalar_d;
            gain_valid_q <= gain_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign scalar     = scalar_q;
    assign shift      = SHIFT;
    assign gain_valid = gain_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_gain_estimator.sv
// Scoreboard bench for gain_estimator: driver models each window,
// monitor checks every gain pulse, its latency and busy.
module tb_gain_estimator;

    localparam int          WIN = 64;
    localparam logic [15:0] TGT = 16'hC000;
    localparam int          SH  = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_in = '0;
    logic [15:0] scalar;
    logic [4:0]  shift;
    logic        gain_valid;
    logic        busy;

    always #5 clk = ~clk;

    gain_estimator #(
        .WINDOW (WIN),
        .TARGET (TGT),
        .SHIFT  (5'(SH))
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .scalar       (scalar),
        .shift        (shift),
        .gain_valid   (gain_valid),
        .busy         (busy)
    );

    typedef struct {
        logic [15:0] val;
        int          stamp;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_peak = 0;
    int   m_count = 0;

    function automatic logic [15:0] ref_gain(input int peak);
        longint q;
        if (peak == 0) return 16'hFFFF;
        q = (longint'(TGT) << SH) / peak;
        return (q > 65535) ? 16'hFFFF : 16'(q);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        logic exp_busy;
        if (!reset) begin
            exp_busy = (sb.size() > 0) && !gain_valid;
            check("busy", 32'(busy), 32'(exp_busy));
            check("shift", 32'(shift), 32'(SH));
            if (gain_valid) begin
                if (sb.size() == 0) begin
                    flag("unexpected_gain_valid");
                end else begin
                    e = sb.pop_front();
                    check("scalar", 32'(scalar), 32'(e.val));
                    check("latency", 32'(cyc), 32'(e.stamp));
                end
            end else if (sb.size() > 0 && cyc > sb[0].stamp) begin
                flag("missing_gain_valid");
                void'(sb.pop_front());
            end
        end
        cyc <= cyc + 1;
    end

    task automatic drive(input bit v, input logic [15:0] d);
        sample_valid = v;
        sample_in    = d;
        @(posedge clk);
        #1;
        if (v) begin
            if (int'(d) > m_peak) m_peak = int'(d);
            m_count++;
            if (m_count == WIN) begin
                sb.push_back('{ref_gain(m_peak), cyc + 32});
                m_peak  = 0;
                m_count = 0;
            end
        end
        sample_valid = 1'b0;
    endtask

    task automatic drive_rst();
        reset        = 1'b1;
        sample_valid = 1'b1;
        sample_in    = 16'hFFFF;
        @(posedge clk);
        #1;
        sb.delete();
        m_peak       = 0;
        m_count      = 0;
        reset        = 1'b0;
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'($urandom));
    endtask

    task automatic window(input logic [15:0] val, input bit gapped);
        for (int i = 0; i < WIN; i++) begin
            if (gapped) drive(1'b0, 16'hFFFF);
            drive(1'b1, val);
        end
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() > 0 && k < 200) begin
            drive(1'b0, 16'h0);
            k++;
        end
        if (sb.size() > 0) flag("drain_timeout");
        idle(2);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(10);
        @(negedge clk);
        check("reset_scalar", 32'(scalar), 32'h0100);
        check("reset_gain_valid", 32'(gain_valid), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_shift", 32'(shift), 32'd8);

        window(16'h6000, 1'b0);
        drain();

        for (int i = 0; i < WIN - 1; i++) drive(1'b1, 16'h1000);
        drive(1'b1, 16'hFFFF);
        drain();

        window(16'h0000, 1'b0);
        drain();
        for (int i = 0; i < WIN - 1; i++) drive(1'b1, 16'h0000);
        drive(1'b1, 16'h0001);
        drain();

        window(16'h3000, 1'b1);
        window(16'h6000, 1'b0);
        drain();

        window(16'h2000, 1'b0);
        idle(9);
        drive_rst();
        @(negedge clk);
        check("abort_scalar", 32'(scalar), 32'h0100);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_gain_valid", 32'(gain_valid), 32'h0);
        idle(30);
        window(16'h4000, 1'b0);
        drain();

        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < WIN; i++) begin
                while ($urandom_range(0, 3) == 0) drive(1'b0, 16'($urandom));
                drive(1'b1, 16'($urandom_range(0, 16'hFFFF) >> $urandom_range(0, 15)));
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
